tcb_lite_trace: RTL and testbench
=================================

Name: tcb_lite_trace

Overview:
- Synthesizable, parametrised TCB-Lite transfer monitor and trace buffer; generalises the simulation-only VIP monitor.
- Passively taps one TCB-Lite manager/subordinate link. Pairs each request with its response after a fixed response delay DLY.
- Records each completed transfer, with its idle and backpressure counts, into a circular on-chip buffer.
- A debug agent drains the buffer through a valid/ready read port. Full behaviour (stop or wrap) is a parameter.

Parameters:
- ADR, 32, address width
- DAT, 32, data width; BEN = DAT/8 byte enables
- DLY, 1, response delay in cycles (0 allowed: response in same cycle as transfer)
- DEPTH, 16, trace entries (power of 2, >=2)
- CNT, 8, width of idle/backpressure/drop counters (saturating)
- WRAP, 0, 0 = stop-on-full (drop new entries), 1 = overwrite oldest

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- vld  in  1  TCB request valid (tapped)
- rdy  in  1  TCB request ready (tapped)
- wen  in  1  TCB write enable
- adr  in  ADR  TCB address
- ben  in  BEN  TCB byte enable
- wdt  in  DAT  TCB write data
- rdt  in  DAT  TCB read data (valid DLY cycles after transfer)
- err  in  1  TCB response error (same timing as rdt)
- clr  in  1  synchronous clear of trace state
- trc_vld  out  1  trace entry available
- trc_rdy  in  1  trace consumer ready
- trc_dat  out  E  entry {wen,adr,ben,wdt,rdt,err,idl[CNT],bpr[CNT]}, E = 2+ADR+BEN+2*DAT+2*CNT
- trc_cnt  out  $clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky: at least one entry dropped or overwritten
- drp  out  CNT  number of lost entries, saturating

Behaviour:
- trn = vld & rdy, evaluated every clk.
- idl counter: +1 on cycles with ~vld & rdy. bpr counter: +1 on cycles with vld & ~rdy. Both saturate at 2^CNT-1.
- ~vld & ~rdy cycles change neither counter.
- On a trn cycle, the current idl/bpr values are captured with the request. Both counters are then set to 0 for the next cycle.
- Delay line: DLY stages of {valid, wen, adr, ben, wdt, idl, bpr}.
  - Shifts every cycle unconditionally; TCB-Lite response latency is fixed.
  - Stage 0 is loaded with trn.
- Capture: when the stage-DLY valid bit is 1, form an entry with that stage's request fields plus the current rdt/err. For DLY=0, use the live request and counters.
- Buffer: DEPTH-entry array with write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Read port is first-word-fall-through:
  - trc_vld = (trc_cnt != 0).
  - trc_dat = entry at the read pointer.
  - Pop when trc_vld & trc_rdy.
- Capture while not full: write the entry and advance the write pointer. Occupancy +1, or unchanged if a pop occurs in the same cycle.
- Capture while full, WRAP=0:
  - If a pop occurs in the same cycle, accept the write normally; occupancy stays DEPTH, no loss.
  - Otherwise drop the entry, set ovf, drp +1 (saturating).
- Capture while full, WRAP=1:
  - Overwrite the oldest entry and advance both pointers.
  - Set ovf, drp +1.
  - If a pop occurs in the same cycle, the consumer takes the oldest entry and the write is accepted without loss. Occupancy stays DEPTH; ovf and drp unchanged.
- Pop with empty buffer: ignored, since trc_vld=0.
- clr = 1 (synchronous, highest priority):
  - Next cycle: pointers, occupancy, ovf, drp, idl, bpr and all delay-line valid bits = 0.
  - Any capture or pop in the clr cycle is discarded.
- Reset (rst=0, asynchronous): same state as clr, plus trc_vld=0, trc_cnt=0, ovf=0, drp=0.
  - Reset mid-transfer discards in-flight delay-line entries.
  - Array contents need no reset.
- Capture-to-trc_vld latency: entry visible on trc_vld in the cycle after its capture cycle. Transfer-to-trc_vld = DLY+1 cycles.

Test Plan:
- DLY=1, rdy=1: idle 3 cycles, then write adr=0x10 wdt=0xA5A5A5A5 -> one entry appears 2 cycles after trn with idl=3, bpr=0, wen=1, err=0.
- DLY=2, read at adr=0x20 with vld held 4 cycles before rdy, rdt=0x12345678 two cycles after trn -> entry bpr=4, idl=0, rdt=0x12345678.
- DEPTH=4, WRAP=0, trc_rdy=0, 6 back-to-back transfers -> trc_cnt=4, entries 1..4 kept, ovf=1, drp=2. Then pop 4 -> trc_cnt=0, ovf still 1.
- DEPTH=4, WRAP=1, same stimulus -> entries 3..6 read out in order, ovf=1, drp=2. Full + simultaneous pop + capture -> trc_cnt stays 4, drp unchanged.
- CNT=4, 20 idle cycles then transfer -> idl=15 (saturated). clr mid-stream with 2 transfers in delay line -> nothing captured, trc_cnt=0, ovf=0.
- Assert rst low asynchronously mid-burst -> all outputs 0 immediately; after release, the first transfer produces a correct entry with idl counted from release.

Source files
------------

// File: rtl/tcb_lite_trace.sv
// Passive TCB-Lite transfer monitor: pairs requests with fixed-latency responses
// and logs each transfer, with its idle/backpressure counts, into a circular trace buffer.
module tcb_lite_trace #(
    parameter  int unsigned ADR   = 32,
    parameter  int unsigned DAT   = 32,
    parameter  int unsigned DLY   = 1,
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned CNT   = 8,
    parameter  int unsigned WRAP  = 0,
    localparam int unsigned BEN   = DAT/8,
    localparam int unsigned E     = 2+ADR+BEN+2*DAT+2*CNT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    input  logic           rdy,
    input  logic           wen,
    input  logic [ADR-1:0] adr,
    input  logic [BEN-1:0] ben,
    input  logic [DAT-1:0] wdt,
    input  logic [DAT-1:0] rdt,
    input  logic           err,
    input  logic           clr,
    output logic           trc_vld,
    input  logic           trc_rdy,
    output logic [E-1:0]   trc_dat,
    output logic [AW:0]    trc_cnt,
    output logic           ovf,
    output logic [CNT-1:0] drp
);

    localparam int unsigned   R       = 1+ADR+BEN+DAT+2*CNT;
    localparam logic [CNT-1:0] CMAX   = '1;
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic          WRAP_EN = (WRAP != 0);

    logic           trn;
    logic [CNT-1:0] idl;
    logic [CNT-1:0] bpr;
    logic [R-1:0]   req_now;
    logic           cap_vld;
    logic [R-1:0]   cap_req;
    logic [E-1:0]   cap_entry;

    assign trn     = vld & rdy;
    assign req_now = {wen, adr, ben, wdt, idl, bpr};

    // Counters restart after every transfer so each entry reports the gap before it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idl <= '0;
            bpr <= '0;
        end else if (clr || trn) begin
            idl <= '0;
            bpr <= '0;
        end else begin
            if (!vld && rdy && idl != CMAX) idl <= idl + CNT'(1);
            if (vld && !rdy && bpr != CMAX) bpr <= bpr + CNT'(1);
        end
    end

    if (DLY == 0) begin : g_nodly
        assign cap_vld = trn;
        assign cap_req = req_now;
    end else begin : g_dly
        logic [DLY-1:0] dl_vld;
        logic [R-1:0]   dl_req [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dl_vld <= '0;
            end else if (clr) begin
                dl_vld <= '0;
            end else begin
                dl_vld[0] <= trn;
                for (int i = 1; i < DLY; i++) dl_vld[i] <= dl_vld[i-1];
            end
        end

        always_ff @(posedge clk) begin
            dl_req[0] <= req_now;
            for (int i = 1; i < DLY; i++) dl_req[i] <= dl_req[i-1];
        end

        assign cap_vld = dl_vld[DLY-1];
        assign cap_req = dl_req[DLY-1];
    end

    // Response fields are spliced in between the request fields and the counters.
    assign cap_entry = {cap_req[R-1:2*CNT], rdt, err, cap_req[2*CNT-1:0]};

    logic [E-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          full;
    logic          pop;
    logic          wr;
    logic          lose;

    assign trc_vld = (trc_cnt != '0);
    assign trc_dat = trc_vld ? mem[rp] : '0;
    assign full    = (trc_cnt == FULL);
    assign pop     = trc_vld & trc_rdy;
    assign wr      = cap_vld & (~full | pop | WRAP_EN);
    assign lose    = cap_vld & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp      <= '0;
            rp      <= '0;
            trc_cnt <= '0;
            ovf     <= 1'b0;
            drp     <= '0;
        end else if (clr) begin
            wp      <= '0;
            rp      <= '0;
            trc_cnt <= '0;
            ovf     <= 1'b0;
            drp     <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            // In wrap mode an unconsumed full write evicts the oldest entry.
            if (pop || (lose && WRAP_EN)) rp <= rp + AW'(1);
            if (wr && !pop && !full) trc_cnt <= trc_cnt + (AW+1)'(1);
            else if (pop && !wr)     trc_cnt <= trc_cnt - (AW+1)'(1);
            if (lose) begin
                ovf <= 1'b1;
                if (drp != CMAX) drp <= drp + CNT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wp] <= cap_entry;
    end

endmodule

// File: tb/tb_tcb_lite_trace.sv
// Scoreboard bench for tcb_lite_trace: three instances with different delay,
// depth, counter width and full policy share one tapped TCB-Lite link.
module tb_tcb_lite_trace;

    localparam int N = 3;
    localparam int P_DLY   [N] = '{1, 2, 0};
    localparam int P_DEPTH [N] = '{4, 4, 8};
    localparam int P_CNT   [N] = '{4, 8, 4};
    localparam int P_WRAP  [N] = '{0, 1, 1};

    typedef struct {
        int          due;
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        int          i;
        int          p;
    } req_t;

    logic        clk;
    logic        rst;
    logic        vld, rdy, wen, err, clr;
    logic [31:0] adr, wdt, rdt;
    logic [3:0]  ben;
    logic [2:0]  trdy;

    logic         vld0, vld1, vld2;
    logic         ovf0, ovf1, ovf2;
    logic [109:0] dat0;
    logic [117:0] dat1;
    logic [109:0] dat2;
    logic [2:0]   cnt0, cnt1;
    logic [3:0]   cnt2;
    logic [3:0]   drp0;
    logic [7:0]   drp1;
    logic [3:0]   drp2;

    logic [127:0] o_dat [N];
    logic [31:0]  o_cnt [N];
    logic [31:0]  o_drp [N];
    logic         o_vld [N];
    logic         o_ovf [N];

    req_t         pend [N][$];
    logic [127:0] sb   [N][$];
    int           m_idl [N];
    int           m_bpr [N];
    int           m_drp [N];
    logic         m_ovf [N];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    tcb_lite_trace #(.ADR(32), .DAT(32), .DLY(1), .DEPTH(4), .CNT(4), .WRAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .wen(wen), .adr(adr), .ben(ben),
        .wdt(wdt), .rdt(rdt), .err(err), .clr(clr), .trc_vld(vld0), .trc_rdy(trdy[0]),
        .trc_dat(dat0), .trc_cnt(cnt0), .ovf(ovf0), .drp(drp0));

    tcb_lite_trace #(.ADR(32), .DAT(32), .DLY(2), .DEPTH(4), .CNT(8), .WRAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .wen(wen), .adr(adr), .ben(ben),
        .wdt(wdt), .rdt(rdt), .err(err), .clr(clr), .trc_vld(vld1), .trc_rdy(trdy[1]),
        .trc_dat(dat1), .trc_cnt(cnt1), .ovf(ovf1), .drp(drp1));

    tcb_lite_trace #(.ADR(32), .DAT(32), .DLY(0), .DEPTH(8), .CNT(4), .WRAP(1)) u_dut2 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .wen(wen), .adr(adr), .ben(ben),
        .wdt(wdt), .rdt(rdt), .err(err), .clr(clr), .trc_vld(vld2), .trc_rdy(trdy[2]),
        .trc_dat(dat2), .trc_cnt(cnt2), .ovf(ovf2), .drp(drp2));

    always_comb begin
        o_dat[0] = 128'(dat0);  o_dat[1] = 128'(dat1);  o_dat[2] = 128'(dat2);
        o_cnt[0] = 32'(cnt0);   o_cnt[1] = 32'(cnt1);   o_cnt[2] = 32'(cnt2);
        o_drp[0] = 32'(drp0);   o_drp[1] = 32'(drp1);   o_drp[2] = 32'(drp2);
        o_vld[0] = vld0;        o_vld[1] = vld1;        o_vld[2] = vld2;
        o_ovf[0] = ovf0;        o_ovf[1] = ovf1;        o_ovf[2] = ovf2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data and error are a pure function of the cycle they are presented in.
    function automatic logic [31:0] rdt_of(int c);
        return (32'(c) * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    function automatic logic err_of(int c);
        return (c % 5) == 3;
    endfunction

    function automatic logic [127:0] mk_entry(req_t q, logic [31:0] r, logic e, int cn);
        logic [127:0] x;
        x = 128'({q.w, q.a, q.b, q.d, r, e});
        x = (x << (2*cn)) | (128'(q.i) << cn) | 128'(q.p);
        return x;
    endfunction

    function automatic int sat_inc(int v, int cn);
        return (v < (1 << cn) - 1) ? v + 1 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < N; k++) begin
            pend[k].delete();
            sb[k].delete();
            m_idl[k] = 0;
            m_bpr[k] = 0;
            m_drp[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("%s_vld%0d", tag, k), 128'(o_vld[k]), '0);
            checkOutput($sformatf("%s_cnt%0d", tag, k), 128'(o_cnt[k]), '0);
            checkOutput($sformatf("%s_ovf%0d", tag, k), 128'(o_ovf[k]), '0);
            checkOutput($sformatf("%s_drp%0d", tag, k), 128'(o_drp[k]), '0);
            checkOutput($sformatf("%s_dat%0d", tag, k), o_dat[k], '0);
        end
    endtask

    // One clock cycle: drive, compare the pre-edge outputs, clock, advance the model.
    task automatic applyStimulus(input logic v, input logic r, input logic w,
                                 input logic [31:0] a, input logic [3:0] b,
                                 input logic [31:0] d, input logic c, input logic [2:0] tr);
        req_t         rq;
        logic [127:0] e;
        bit           pop, cap, full;
        vld = v; rdy = r; wen = w; adr = a; ben = b; wdt = d; clr = c; trdy = tr;
        rdt = rdt_of(cyc);
        err = err_of(cyc);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("vld%0d", k), 128'(o_vld[k]), 128'(sb[k].size() != 0));
            checkOutput($sformatf("cnt%0d", k), 128'(o_cnt[k]), 128'(sb[k].size()));
            checkOutput($sformatf("ovf%0d", k), 128'(o_ovf[k]), 128'(m_ovf[k]));
            checkOutput($sformatf("drp%0d", k), 128'(o_drp[k]), 128'(m_drp[k]));
            if (tr[k] && sb[k].size() != 0)
                checkOutput($sformatf("dat%0d", k), o_dat[k], sb[k][0]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (c) begin
                pend[k].delete();
                sb[k].delete();
                m_idl[k] = 0; m_bpr[k] = 0; m_drp[k] = 0; m_ovf[k] = 1'b0;
            end else begin
                pop = tr[k] && sb[k].size() != 0;
                if (v && r) begin
                    rq = '{due: cyc + P_DLY[k], w: w, a: a, b: b, d: d, i: m_idl[k], p: m_bpr[k]};
                    pend[k].push_back(rq);
                    m_idl[k] = 0;
                    m_bpr[k] = 0;
                end else if (!v && r) begin
                    m_idl[k] = sat_inc(m_idl[k], P_CNT[k]);
                end else if (v && !r) begin
                    m_bpr[k] = sat_inc(m_bpr[k], P_CNT[k]);
                end
                cap = 0;
                if (pend[k].size() != 0 && pend[k][0].due == cyc) begin
                    rq  = pend[k].pop_front();
                    e   = mk_entry(rq, rdt_of(cyc), err_of(cyc), P_CNT[k]);
                    cap = 1;
                end
                full = sb[k].size() == P_DEPTH[k];
                if (cap) begin
                    if (!full || pop) begin
                        if (pop) void'(sb[k].pop_front());
                        sb[k].push_back(e);
                    end else begin
                        if (P_WRAP[k] != 0) begin
                            void'(sb[k].pop_front());
                            sb[k].push_back(e);
                        end
                        m_ovf[k] = 1'b1;
                        m_drp[k] = sat_inc(m_drp[k], P_CNT[k]);
                    end
                end else if (pop) begin
                    void'(sb[k].pop_front());
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [2:0] tr);
        repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, tr);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] tr);
        applyStimulus(1'b1, 1'b1, w, a, 4'hF, d, 1'b0, tr);
    endtask

    task automatic clearTrace();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 3'b000);
    endtask

    initial begin
        rst = 1'b0; vld = 1'b0; rdy = 1'b0; wen = 1'b0; clr = 1'b0; err = 1'b0;
        adr = '0; wdt = '0; rdt = '0; ben = '0; trdy = '0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("por");
        rst = 1'b1;

        // Three idle cycles then a write: idl=3, bpr=0.
        idle(3, 3'b000);
        xfer(1'b1, 32'h10, 32'hA5A5A5A5, 3'b000);
        idle(3, 3'b000);
        checkOutput("s1_idl", 128'(dat0[7:4]), 128'd3);
        checkOutput("s1_bpr", 128'(dat0[3:0]), 128'd0);
        checkOutput("s1_wen", 128'(dat0[109]), 128'd1);
        checkOutput("s1_adr", 128'(dat0[108:77]), 128'h10);
        idle(4, 3'b111);

        // Request held for four cycles of backpressure.
        clearTrace();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 3'b000);
        idle(3, 3'b000);
        checkOutput("s2_bpr", 128'(dat1[7:0]), 128'd4);
        checkOutput("s2_idl", 128'(dat1[15:8]), 128'd0);
        idle(4, 3'b111);

        // Six back-to-back transfers into a stalled consumer.
        clearTrace();
        for (int i = 0; i < 6; i++) xfer(1'b1, 32'h100 + 32'(i), 32'hC0DE0000 + 32'(i), 3'b000);
        idle(3, 3'b000);
        checkOutput("s3_cnt0", 128'(cnt0), 128'd4);
        checkOutput("s3_ovf0", 128'(ovf0), 128'd1);
        checkOutput("s3_drp0", 128'(drp0), 128'd2);
        checkOutput("s3_cnt1", 128'(cnt1), 128'd4);
        checkOutput("s3_drp1", 128'(drp1), 128'd2);
        checkOutput("s3_cnt2", 128'(cnt2), 128'd6);

        // Full wrap buffer with pop and capture in the same cycles.
        xfer(1'b0, 32'h200, 32'h0, 3'b000);
        xfer(1'b0, 32'h204, 32'h0, 3'b000);
        xfer(1'b0, 32'h208, 32'h0, 3'b010);
        idle(2, 3'b010);
        checkOutput("s3_cnt1_pop", 128'(cnt1), 128'd4);
        checkOutput("s3_drp1_pop", 128'(drp1), 128'd2);
        idle(12, 3'b111);
        checkOutput("s3_ovf0_drained", 128'(ovf0), 128'd1);
        checkOutput("s3_ovf1_drained", 128'(ovf1), 128'd1);

        // Long idle: saturates the 4-bit counter, not the 8-bit one.
        clearTrace();
        idle(20, 3'b000);
        xfer(1'b0, 32'h30, 32'h0, 3'b000);
        idle(3, 3'b000);
        checkOutput("s4_idl0", 128'(dat0[7:4]), 128'd15);
        checkOutput("s4_idl1", 128'(dat1[15:8]), 128'd20);
        idle(2, 3'b111);
        repeat (18) applyStimulus(1'b1, 1'b0, 1'b1, 32'h34, 4'h3, 32'h55AA, 1'b0, 3'b111);
        xfer(1'b1, 32'h34, 32'h55AA, 3'b111);
        idle(4, 3'b111);

        // Clear while transfers are still in flight.
        xfer(1'b1, 32'h40, 32'h1, 3'b000);
        xfer(1'b1, 32'h44, 32'h2, 3'b000);
        clearTrace();
        idle(4, 3'b000);
        checkOutput("s5_cnt0", 128'(cnt0), 128'd0);
        checkOutput("s5_cnt1", 128'(cnt1), 128'd0);
        checkOutput("s5_ovf1", 128'(ovf1), 128'd0);

        repeat (300) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom(), 4'($urandom()), $urandom(),
                          1'($urandom_range(0, 60) == 0), 3'($urandom()));
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) xfer(1'b1, 32'h300 + 32'(i), $urandom(), 3'b000);
        #3;
        rst = 1'b0;
        #1;
        checkResetState("arst");
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2, 3'b000);
        xfer(1'b1, 32'h400, 32'hDEADBEEF, 3'b000);
        idle(3, 3'b000);
        checkOutput("s6_idl0", 128'(dat0[7:4]), 128'd2);
        checkOutput("s6_idl1", 128'(dat1[15:8]), 128'd2);
        idle(6, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
